// File: rtl/msg_sequencer.sv
// Steps a host-written ASCII buffer through the LED matrix character lookup,
// one character per HOLD cycles with an optional GAP blank, once or looping.
module msg_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4,
  parameter int HOLD    = 12_000_000,
  parameter int GAP     = 1_200_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  input  logic [AW:0]   msg_len,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [7:0]    char,
  output logic [AW-1:0] char_idx,
  output logic          load,
  output logic          busy,
  output logic          done
);

  // Handshake: none of the ports use valid/ready. start is a level sampled
  // only in IDLE; load is a one-cycle strobe marking img valid downstream.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(HOLD - 1);
  localparam logic [31:0] GAP_LAST  = (GAP > 0) ? 32'(GAP - 1) : 32'd0;
  localparam logic [AW:0] MAX_LEN_W = (AW + 1)'(MAX_LEN);
  localparam logic [AW:0] ONE_W     = (AW + 1)'(1);

  // Current FSM state, kept as a named signal for probing and checker binding.
  state_t      state;

  logic [7:0]  mem [MAX_LEN];
  logic [31:0] timer;
  logic [AW:0] len_q;
  logic        loop_q;
  logic        char_wr;

  logic          wr_ok;
  logic [AW:0]   start_len;
  logic [AW:0]   next_idx_w;
  logic [AW-1:0] next_idx;
  logic          last_char;

  state_t        adv_state;
  logic [7:0]    adv_char;
  logic [AW-1:0] adv_idx;
  logic          adv_done;
  logic          adv_busy;

  always_comb begin
    wr_ok      = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < MAX_LEN_W);
    start_len  = (msg_len > MAX_LEN_W) ? MAX_LEN_W : msg_len;
    next_idx_w = {1'b0, char_idx} + ONE_W;
    next_idx   = next_idx_w[AW-1:0];
    last_char  = (next_idx_w >= len_q);
  end

  // What happens at the end of a character slot (after HOLD, or after GAP).
  always_comb begin
    adv_state = S_SHOW;
    adv_char  = mem[next_idx];
    adv_idx   = next_idx;
    adv_done  = 1'b0;
    adv_busy  = 1'b1;
    if (last_char) begin
      if (loop_q) begin
        adv_char = mem[0];
        adv_idx  = '0;
      end else begin
        adv_state = S_IDLE;
        adv_char  = 8'h00;
        adv_idx   = char_idx;
        adv_done  = 1'b1;
        adv_busy  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      char     <= 8'h00;
      char_idx <= '0;
      load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timer    <= 32'd0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      char_wr  <= 1'b0;
    end else begin
      // The lookup registers char once, so img is valid one edge after char_wr.
      load    <= char_wr;
      char_wr <= 1'b0;
      done    <= 1'b0;
      if (stop) begin
        if (state != S_IDLE) begin
          char_wr <= 1'b1;
        end
        state    <= S_IDLE;
        char     <= 8'h00;
        char_idx <= '0;
        busy     <= 1'b0;
        timer    <= 32'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (msg_len != '0)) begin
              state    <= S_SHOW;
              busy     <= 1'b1;
              len_q    <= start_len;
              loop_q   <= loop;
              char_idx <= '0;
              char     <= mem[0];
              timer    <= 32'd0;
              char_wr  <= 1'b1;
            end
          end
          S_SHOW: begin
            if (timer == HOLD_LAST) begin
              timer   <= 32'd0;
              char_wr <= 1'b1;
              if (GAP > 0) begin
                state <= S_GAP;
                char  <= 8'h00;
              end else begin
                state    <= adv_state;
                char     <= adv_char;
                char_idx <= adv_idx;
                done     <= adv_done;
                busy     <= adv_busy;
              end
            end else begin
              timer <= timer + 32'd1;
            end
          end
          S_GAP: begin
            if (timer == GAP_LAST) begin
              timer    <= 32'd0;
              char_wr  <= 1'b1;
              state    <= adv_state;
              char     <= adv_char;
              char_idx <= adv_idx;
              done     <= adv_done;
              busy     <= adv_busy;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            char  <= 8'h00;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    busy == (state != S_IDLE));
  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    done |-> !busy);
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    busy |-> ({1'b0, char_idx} < len_q));

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed bench for msg_sequencer: one instance with a blank gap, one without.
module tb_msg_sequencer;

  localparam int HOLD  = 4;
  localparam int GAP_A = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_char;
  logic [4:0] msg_len;
  logic       loop;
  logic       start;
  logic       stop;

  logic [7:0] char_a, char_b;
  logic [3:0] idx_a, idx_b;
  logic       load_a, load_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  msg_sequencer #(.MAX_LEN(16), .AW(4), .HOLD(HOLD), .GAP(GAP_A)) u_dut_gap (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .msg_len(msg_len), .loop(loop), .start(start), .stop(stop),
    .char(char_a), .char_idx(idx_a), .load(load_a), .busy(busy_a), .done(done_a)
  );

  msg_sequencer #(.MAX_LEN(16), .AW(4), .HOLD(HOLD), .GAP(0)) u_dut_nogap (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .msg_len(msg_len), .loop(loop), .start(start), .stop(stop),
    .char(char_b), .char_idx(idx_b), .load(load_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] msg_ref [16];
  logic [7:0] exp_q [$];

  typedef struct {
    logic       start;
    logic       stop;
    logic       wr;
    logic [3:0] wr_addr;
    logic [7:0] wr_char;
    logic [7:0] e_char;
    logic [3:0] e_idx;
    logic       chk_idx;
    logic       e_load;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs [21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic write_char(input logic [3:0] a, input logic [7:0] c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_char = c;
    tick();
    wr_en = 1'b0;
    msg_ref[a] = c;
  endtask

  task automatic idle_both();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  // Start playback and compare against the timing formula of the message.
  task automatic run_seq(input int mlen, input int eff, input bit lp, input bit use0,
                         input int ncyc, input string tag);
    int per;
    logic [7:0] e;
    per = use0 ? HOLD : HOLD + GAP_A;
    exp_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      int slot;
      int ph;
      slot = k / per;
      ph   = k % per;
      if (!lp && slot >= eff) exp_q.push_back(8'h00);
      else if (ph < HOLD) exp_q.push_back(msg_ref[slot % eff]);
      else exp_q.push_back(8'h00);
    end
    msg_len = 5'(mlen);
    loop    = lp;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      chk($sformatf("%s char k=%0d", tag, k), 32'(use0 ? char_b : char_a), 32'(e));
      chk($sformatf("%s busy k=%0d", tag, k), 32'(use0 ? busy_b : busy_a),
          32'(lp || (k < eff * per)));
      chk($sformatf("%s done k=%0d", tag, k), 32'(use0 ? done_b : done_a),
          32'(!lp && (k == eff * per)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h48, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h48, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h48, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h48, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h49, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h49, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h49, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd2, 8'h5A, 8'h49, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h21, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h21, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h21, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h21, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // clock/reset
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_char = 8'h00;
    msg_len = 5'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 16; i++) msg_ref[i] = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset char", 32'(char_a), 32'h00);
    chk("reset idx", 32'(idx_a), 32'd0);
    chk("reset load", 32'(load_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset busy nogap", 32'(busy_b), 32'd0);

    write_char(4'd0, 8'h48);
    write_char(4'd1, 8'h49);
    write_char(4'd2, 8'h21);

    // zero-length start is ignored
    msg_len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0 busy", 32'(busy_a), 32'd0);
    chk("len0 busy nogap", 32'(busy_b), 32'd0);
    tick();
    chk("len0 load", 32'(load_a), 32'd0);

    // start and stop together in idle
    msg_len = 5'd3; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", 32'(busy_a), 32'd0);
    chk("start+stop char", 32'(char_a), 32'h00);
    tick();
    chk("start+stop load", 32'(load_a), 32'd0);

    // basic playback table, with restart and write attempts while busy
    msg_len = 5'd3; loop = 1'b0;
    for (int k = 0; k < 21; k++) begin
      start   = vecs[k].start;
      stop    = vecs[k].stop;
      wr_en   = vecs[k].wr;
      wr_addr = vecs[k].wr_addr;
      wr_char = vecs[k].wr_char;
      tick();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      if (k == 0) begin
        msg_len = 5'd1;
        loop    = 1'b1;
      end
      chk($sformatf("vec%0d char", k), 32'(char_a), 32'(vecs[k].e_char));
      if (vecs[k].chk_idx) chk($sformatf("vec%0d idx", k), 32'(idx_a), 32'(vecs[k].e_idx));
      chk($sformatf("vec%0d load", k), 32'(load_a), 32'(vecs[k].e_load));
      chk($sformatf("vec%0d busy", k), 32'(busy_a), 32'(vecs[k].e_busy));
      chk($sformatf("vec%0d done", k), 32'(done_a), 32'(vecs[k].e_done));
    end
    loop = 1'b0;
    idle_both();

    // replay: address 2 must still hold the pre-playback character
    run_seq(3, 3, 1'b0, 1'b0, 20, "replay");
    idle_both();

    // no gap
    write_char(4'd0, 8'h41);
    write_char(4'd1, 8'h42);
    run_seq(2, 2, 1'b0, 1'b1, 12, "nogap");
    idle_both();

    // loop then stop
    write_char(4'd0, 8'h4F);
    write_char(4'd1, 8'h4B);
    msg_len = 5'd2; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      chk($sformatf("loop char k=%0d", k), 32'(char_a),
          32'(((k % 6) < HOLD) ? msg_ref[(k / 6) % 2] : 8'h00));
      chk($sformatf("loop idx k=%0d", k), 32'(idx_a), 32'((k / 6) % 2));
      chk($sformatf("loop done k=%0d", k), 32'(done_a), 32'd0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; loop = 1'b0;
    chk("stop char", 32'(char_a), 32'h00);
    chk("stop busy", 32'(busy_a), 32'd0);
    chk("stop idx", 32'(idx_a), 32'd0);
    chk("stop load early", 32'(load_a), 32'd0);
    chk("stop done", 32'(done_a), 32'd0);
    tick();
    chk("stop load", 32'(load_a), 32'd1);
    chk("stop done late", 32'(done_a), 32'd0);
    idle_both();

    // reset held for three cycles mid-SHOW
    msg_len = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d char", i), 32'(char_a), 32'h00);
      chk($sformatf("rst%0d idx", i), 32'(idx_a), 32'd0);
      chk($sformatf("rst%0d load", i), 32'(load_a), 32'd0);
      chk($sformatf("rst%0d busy", i), 32'(busy_a), 32'd0);
      chk($sformatf("rst%0d done", i), 32'(done_a), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("post-rst load", 32'(load_a), 32'd0);
    chk("post-rst busy", 32'(busy_a), 32'd0);
    chk("post-rst busy nogap", 32'(busy_b), 32'd0);

    // length clamp: msg_len 20 plays all 16 entries
    for (int i = 0; i < 16; i++) write_char(4'(i), 8'(8'h61 + i));
    run_seq(20, 16, 1'b0, 1'b0, 100, "clamp");
    idle_both();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msg_sequencer.md
# msg_sequencer

Sequences an ASCII message through the 6x6 LED matrix character lookup, one character at a time. It holds a small message buffer written by the host logic and, on start, steps through it with a programmable per-character hold time and an optional blank gap, once or looping. It drives the lookup's 8-bit `data` input. It pulses `load` to tell the downstream matrix driver when the lookup's registered `img` output is valid.

## Interface
- `MAX_LEN`, 16: message buffer depth in characters.
- `AW`, 4: buffer address width; must equal clog2(`MAX_LEN`).
- `HOLD`, 12_000_000: cycles each character is shown; must be at least 1.
- `GAP`, 1_200_000: blank cycles after each character; 0 disables the gap.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  AW  buffer write address.
- `wr_char`  in  8  ASCII code to write.
- `msg_len`  in  AW+1  number of characters to play; sampled at start.
- `loop`  in  1  repeat the message forever; sampled at start.
- `start`  in  1  begin playback; acted on only when idle.
- `stop`  in  1  abort playback.
- `char`  out  8  ASCII code to the lookup; 0x00 means blank.
- `char_idx`  out  AW  buffer index of the current character.
- `load`  out  1  one-cycle pulse: the lookup `img` is valid this cycle.
- `busy`  out  1  high while playing.
- `done`  out  1  one-cycle pulse when a non-loop message completes.

## Operation
- **Buffer**
  - MAX_LEN x 8 storage, not reset; contents are undefined until written.
  - A write takes effect only when `wr_en` is high, the block is idle, and `wr_addr` < MAX_LEN; otherwise it is ignored.
- **States:** IDLE, SHOW, GAP.
- **IDLE**
  - `char`=0x00 and `busy`=0.
  - `start` with `msg_len`≠0 and no `stop`: go to SHOW. Latch `loop`, and latch length = min(`msg_len`, MAX_LEN).
  - On that transition: `char_idx`←0, `char`←buf[0], timer←0.
  - `start` with `msg_len`=0 is ignored.
- **SHOW**
  - Timer counts 0..HOLD-1. When it reaches HOLD-1:
    - GAP>0: go to GAP with `char`←0x00 and timer←0.
    - GAP=0: advance (see below).
- **GAP**
  - Timer counts 0..GAP-1, then advance.
- **Advance**
  - If `char_idx` < length-1: `char_idx`+1, `char`←buf[idx+1], go to SHOW.
  - Else if looping: `char_idx`←0, `char`←buf[0], go to SHOW.
  - Else: go to IDLE with `char`←0x00 and pulse `done`.
- **`stop`**
  - Highest priority in every state: go to IDLE next edge with `char`←0x00 and `char_idx`←0. No `done`.
  - `stop` together with `start` in IDLE: remain idle.
- **Ignored inputs:** `start` while busy; `msg_len`/`loop` changes while busy.
- **`load`:** asserted for exactly one cycle following every cycle in which `char` was written, including blanking on entry to GAP or IDLE. This matches the lookup's one-register latency.
- **Timer:** 32 bits wide; it must not wrap within HOLD or GAP.

## Timing
- **Reset:** state IDLE; `char`=0x00, `char_idx`=0, `load`=0, `busy`=0, `done`=0; timer=0. Reset mid-playback behaves like `stop`, except `load` is not pulsed.
- **Start:** `start` sampled at edge T. After T: `busy`=1 and `char`=buf[0]. `load`=1 in the cycle after edge T+1.
- **Per-character period:** HOLD+GAP cycles.
  - Character k is presented at edge T + k·(HOLD+GAP).
  - Blanking occurs at T + k·(HOLD+GAP) + HOLD.
- **Non-loop completion:** at edge T + N·(HOLD+GAP), `busy`→0, `char`→0x00, and `done`=1 for one cycle. `load` follows one cycle later.
- **Back-to-back start:** `start` in the first IDLE cycle after `done` is accepted.
- **Writes:** a write at edge W is visible to a start accepted at edge W+1 or later.

## Test plan
- **Reset:** assert `rst` 3 cycles mid-SHOW -> all outputs at reset values, no `load` pulse, `busy`=0.
- **Basic playback:** HOLD=4, GAP=2; write "HI!" at 0..2, start with `msg_len`=3, `loop`=0 -> `char` sequence H×4, 0×2, I×4, 0×2, !×4, 0×2. One `load` follows each `char` change. `done` at T+18 and `busy` falls at T+18.
- **No gap:** GAP=0, `msg_len`=2 "AB" -> A×4, B×4, then 0x00. `done` at T+8. No blank between A and B.
- **Loop and stop:** "OK", `loop`=1 -> the O,0,K,0 pattern repeats with `char_idx` wrapping 1→0. `stop` at T+20 -> `char`=0 next edge, `load` one cycle later, no `done`.
- **Ignored inputs:**
  - `start` with `msg_len`=0 -> stays IDLE.
  - `start` while busy -> no restart.
  - Write to addr 2 while busy -> buffer unchanged; readback by replaying shows the old character.
- **Clamp and priority:** `msg_len`=20 with MAX_LEN=16 -> plays 16 characters then `done`. `start`+`stop` together in IDLE -> stays IDLE.
